// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, bit-serial shifts and a shift-add multiplier.
// One operation is in flight at a time; result and flags are registered and held until the next op.
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             Negative,
   output logic             carry,
   output logic             overflow
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_SLL = 4'h5;
   localparam logic [3:0] OP_SRL = 4'h6;
   localparam logic [3:0] OP_SRA = 4'h7;
   localparam logic [3:0] OP_MUL = 4'h8;

   // Counter must hold WIDTH itself for the multiply step count.
   localparam int CW = SHW + 1;

   logic [1:0]         state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH-1:0]   sh_next;
   logic               sh_out;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   logic               wr;
   logic [WIDTH-1:0]   new_res;
   logic               new_c;
   logic               new_v;

   assign shamt    = b[SHW-1:0];
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};

   // Accumulator is {partial product high half, remaining multiplier bits}; one step per cycle.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   always_comb begin
      sh_next = opa_q;
      sh_out  = 1'b0;
      case (op_q)
         OP_SLL: begin
            sh_next = {opa_q[WIDTH-2:0], 1'b0};
            sh_out  = opa_q[WIDTH-1];
         end
         OP_SRL: begin
            sh_next = {1'b0, opa_q[WIDTH-1:1]};
            sh_out  = opa_q[0];
         end
         OP_SRA: begin
            sh_next = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            sh_out  = opa_q[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opa_d   = opa_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      wr      = 1'b0;
      new_res = '0;
      new_c   = 1'b0;
      new_v   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = ALUOp;
               opa_d   = a;
               acc_d   = {{WIDTH{1'b0}}, b};
               cnt_d   = {1'b0, shamt};
               state_d = DONE;
               wr      = 1'b1;
               case (ALUOp)
                  OP_AND: new_res = a & b;
                  OP_ADD: begin
                     {new_c, new_res} = add_full;
                     new_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_SUB: begin
                     {new_c, new_res} = sub_full;
                     new_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_OR:  new_res = a | b;
                  OP_XOR: new_res = a ^ b;
                  OP_SLL, OP_SRL, OP_SRA: begin
                     if (shamt != '0) begin
                        wr      = 1'b0;
                        state_d = RUN;
                     end else begin
                        new_res = a;
                     end
                  end
                  OP_MUL: begin
                     wr      = 1'b0;
                     state_d = RUN;
                     cnt_d   = CW'(WIDTH);
                  end
                  default: ;
               endcase
            end
         end

         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_next;
            end else begin
               opa_d = sh_next;
            end
            if (cnt_q == CW'(1)) begin
               wr      = 1'b1;
               state_d = DONE;
               if (op_q == OP_MUL) begin
                  new_res = mul_next[WIDTH-1:0];
                  new_c   = |mul_next[2*WIDTH-1:WIDTH];
               end else begin
                  new_res = sh_next;
                  new_c   = sh_out;
               end
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wr) begin
         res_d   = new_res;
         carry_d = new_c;
         ovf_d   = new_v;
         zero_d  = (new_res == '0);
         neg_d   = new_res[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         opa_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = res_q;
   assign zero     = zero_q;
   assign Negative = neg_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: datapath width, a power of two from 4 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  1: request to begin an operation; accepted only in IDLE.
REQ-006 Port ALUOp  input  4: operation code, sampled when start is accepted.
REQ-007 Port a  input  WIDTH: first operand, sampled when start is accepted.
REQ-008 Port b  input  WIDTH: second operand (shift amount = b[SHW-1:0]), sampled when start is accepted.
REQ-009 Port busy  output  1: high while an accepted operation is in progress.
REQ-010 Port done  output  1: single-cycle pulse when result and flags become valid.
REQ-011 Port result  output  WIDTH: registered result, held until the next accepted start.
REQ-012 Ports zero, Negative, carry, overflow  output  1 each: registered flags, updated with result.

Function
REQ-013 ALUOp encodings SHALL be: 0000 AND, 0001 ADD, 0010 SUB, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 MUL (unsigned, low WIDTH bits).
REQ-014 Unlisted codes SHALL produce result 0, carry 0, overflow 0, zero 1, with latency 1.
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE with start=1: latch a, b and ALUOp; go to RUN for MUL or for a shift with nonzero amount, otherwise compute and go to DONE.
REQ-017 RUN, shifts: shift one bit per cycle and decrement the counter; go to DONE after the last bit.
REQ-018 RUN, MUL: one shift-add step per cycle for WIDTH cycles, with a 2*WIDTH-bit internal accumulator; then go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency, counted from the accepting edge to the edge that sets done: 1 for AND/ADD/SUB/OR/XOR/illegal codes and for shift amount 0; amount+1 for shifts; WIDTH+1 for MUL.
REQ-021 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle; latched operands SHALL NOT change.
REQ-023 ADD: {carry,result} = a+b; overflow = (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
REQ-024 SUB: {carry,result} = a-b, with carry as the raw bit WIDTH (1 = borrow); overflow = (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]).
REQ-025 SLL/SRL/SRA: carry = last bit shifted out, or 0 for amount 0; SRA replicates a[W-1]; overflow = 0.
REQ-026 MUL: carry = OR of the upper WIDTH product bits; overflow = 0.
REQ-027 AND/OR/XOR: carry = 0, overflow = 0.
REQ-028 For all ops: zero = (result==0) and Negative = result[W-1], both registered in the same cycle as result.
REQ-029 result and flags SHALL change only on the cycle done rises, or on reset.

Reset
REQ-030 While rst_n=0, and asynchronously on its falling edge: state=IDLE, busy=0, done=0, result=0, zero=0, Negative=0, carry=0, overflow=0, counters and accumulator cleared.
REQ-031 Reset mid-operation SHALL discard the operation with no done pulse; a start on the first rising edge with rst_n=1 SHALL be accepted.

Verification (WIDTH=16)
REQ-032 ADD a=0x7FFF b=0x0001 -> one cycle later done=1, result=0x8000, overflow=1, carry=0, Negative=1, zero=0.
REQ-033 SUB a=0x0000 b=0x0001 -> result=0xFFFF, carry=1, overflow=0, Negative=1; SUB a=b=0x1234 -> zero=1.
REQ-034 SRL a=0x8001 b=1 -> done after 2 cycles, result=0x4000, carry=1; SRA a=0x8000 b=15 -> result=0xFFFF after 16 cycles; SLL b=0 -> result=a after 1 cycle.
REQ-035 MUL a=0x0100 b=0x0100 -> done 17 cycles after start, result=0x0000, carry=1, zero=1; MUL 0x0003*0x0005 -> 0x000F, carry=0.
REQ-036 A start pulse with new operands during MUL RUN and during the DONE cycle -> ignored, original result delivered, busy profile unchanged.
REQ-037 rst_n low for 1 cycle at MUL step 8 -> all outputs 0 immediately, no done; ADD 2+3 started next -> result=0x0005 after 1 cycle.
